// File: rtl/i2c_tx_ctrl_if.sv
// Byte-transmit controller bus bundle.
// Groups the start request, the external shift-register handshake, the
// sampled/driven I2C line levels and the status outputs.
//   master : the controller (i2c_tx_ctrl) -- drives strobes, line levels, status
//   slave  : the environment -- drives tx_start, sr_serial, sda_in
interface i2c_tx_ctrl_if;
    logic tx_start;
    logic sr_serial;
    logic sda_in;
    logic load_enable;
    logic shift_enable;
    logic scl_out;
    logic sda_out;
    logic busy;
    logic done;
    logic ack_err;

    modport master (
        input  tx_start, sr_serial, sda_in,
        output load_enable, shift_enable, scl_out, sda_out, busy, done, ack_err
    );

    modport slave (
        output tx_start, sr_serial, sda_in,
        input  load_enable, shift_enable, scl_out, sda_out, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_tx_ctrl.sv
// I2C single-byte transmit controller.
// Generates START, eight MSB-first data bits taken from an external
// parallel-to-serial shift register, an ACK slot, and STOP.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : i2c_tx_ctrl_if.master
//           in  : tx_start, sr_serial, sda_in
//           out : load_enable, shift_enable, scl_out, sda_out, busy, done, ack_err
// HALF_PERIOD (2..255) sets the clk cycles per SCL half-period.
module i2c_tx_ctrl #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    i2c_tx_ctrl_if.master bus
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned BCNT_W  = 3;
    localparam logic [TIMER_W-1:0] PHASE_LAST = TIMER_W'(HALF_PERIOD - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        BIT_LOW,
        BIT_HIGH,
        ACK_LOW,
        ACK_HIGH,
        STOP_LOW,
        STOP_HIGH,
        DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [BCNT_W-1:0]   bit_cnt_q;
    logic                ack_err_q;
    logic                phase_end;

    logic load_enable_c;
    logic shift_enable_c;
    logic scl_out_c;
    logic sda_out_c;
    logic busy_c;
    logic done_c;

    assign phase_end = (timer_q == PHASE_LAST);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoded outputs; line levels come from state_q only,
    // except SDA in bit phases which follows the shift register output.
    always_comb begin
        state_d        = state_q;
        load_enable_c  = 1'b0;
        shift_enable_c = 1'b0;
        scl_out_c      = 1'b1;
        sda_out_c      = 1'b1;
        busy_c         = 1'b1;
        done_c         = 1'b0;

        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.tx_start) begin
                    // n_rst gate keeps the strobe quiet while reset is held
                    load_enable_c = n_rst;
                    state_d       = START;
                end
            end
            START: begin
                sda_out_c = 1'b0;
                if (phase_end) state_d = BIT_LOW;
            end
            BIT_LOW: begin
                scl_out_c = 1'b0;
                sda_out_c = bus.sr_serial;
                if (phase_end) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                sda_out_c = bus.sr_serial;
                if (phase_end) begin
                    shift_enable_c = 1'b1;
                    state_d        = (bit_cnt_q == BCNT_W'(7)) ? ACK_LOW : BIT_LOW;
                end
            end
            ACK_LOW: begin
                scl_out_c = 1'b0;
                if (phase_end) state_d = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (phase_end) state_d = STOP_LOW;
            end
            STOP_LOW: begin
                scl_out_c = 1'b0;
                sda_out_c = 1'b0;
                if (phase_end) state_d = STOP_HIGH;
            end
            STOP_HIGH: begin
                sda_out_c = 1'b0;
                if (phase_end) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, parked at 0 in IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // Bit counter: cleared when a byte is accepted, advanced per SCL-high end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_q <= '0;
        end else if ((state_q == IDLE) && (state_d == START)) begin
            bit_cnt_q <= '0;
        end else if ((state_q == BIT_HIGH) && phase_end) begin
            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
        end
    end

    // ACK sample at the end of the ACK clock-high phase; held until next sample
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ack_err_q <= 1'b0;
        end else if ((state_q == ACK_HIGH) && phase_end) begin
            ack_err_q <= bus.sda_in;
        end
    end

    assign bus.load_enable  = load_enable_c;
    assign bus.shift_enable = shift_enable_c;
    assign bus.scl_out      = scl_out_c;
    assign bus.sda_out      = sda_out_c;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.ack_err      = ack_err_q;

endmodule

// File: doc/i2c_tx_ctrl.md
I2C_TX_CTRL -- requirements
Module: i2c_tx_ctrl

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per SCL half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset; asynchronous, active-low.
REQ-004 tx_start  input  1  request to send one byte; sampled only in IDLE.
REQ-005 sr_serial  input  1  serial_out of the external 8-bit MSB-first parallel-to-serial shift register; the register fills with 1s.
REQ-006 sda_in  input  1  sampled SDA line; used for ACK.
REQ-007 load_enable  output  1  load strobe to the shift register.
REQ-008 shift_enable  output  1  shift strobe to the shift register.
REQ-009 scl_out  output  1  SCL drive level; 1 = released.
REQ-010 sda_out  output  1  SDA drive level; 1 = released.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at byte completion.
REQ-013 ack_err  output  1  result of the last ACK sample; 1 = NACK; holds until the next ACK sample.

Function
REQ-014 States SHALL be IDLE, START, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH, STOP_LOW, STOP_HIGH, DONE.
REQ-015 A phase timer SHALL count 0..HALF_PERIOD-1, clear on every state change, and mark "phase end" at HALF_PERIOD-1.
REQ-016 A 3-bit bit counter SHALL clear on entry to START and increment on each BIT_HIGH phase end.
REQ-017 IDLE: scl_out=1, sda_out=1; when tx_start=1, load_enable=1 in that same cycle (combinational), then go to START on the next edge.
REQ-018 START: scl_out=1, sda_out=0; at phase end, go to BIT_LOW.
REQ-019 BIT_LOW: scl_out=0, sda_out=sr_serial; at phase end, go to BIT_HIGH.
REQ-020 BIT_HIGH: scl_out=1, sda_out=sr_serial.
REQ-021 BIT_HIGH phase end: shift_enable=1 for exactly that cycle; go to ACK_LOW if bit counter=7, else to BIT_LOW.
REQ-022 ACK_LOW: scl_out=0, sda_out=1; at phase end, go to ACK_HIGH.
REQ-023 ACK_HIGH: scl_out=1, sda_out=1; at phase end, register ack_err<=sda_in and go to STOP_LOW.
REQ-024 STOP_LOW: scl_out=0, sda_out=0.
REQ-025 STOP_HIGH: scl_out=1, sda_out=0; at phase end, go to DONE.
REQ-026 DONE: scl_out=1, sda_out=1, done=1 for one cycle; then unconditionally go to IDLE.
REQ-027 tx_start SHALL be ignored in every state except IDLE, including DONE; load_enable SHALL never assert outside IDLE.
REQ-028 load_enable and shift_enable SHALL never be high in the same cycle.
REQ-029 Exactly 8 shift_enable pulses SHALL occur per byte.
REQ-030 Latency: with tx_start at cycle 0, done SHALL assert at cycle 21*HALF_PERIOD+1.
REQ-031 A new tx_start is accepted no earlier than cycle 21*HALF_PERIOD+2.
REQ-032 scl_out, sda_out (except during bit phases) and busy SHALL be decoded from registered state only.

Reset
REQ-033 While n_rst=0, the block SHALL hold: state IDLE, timer 0, bit counter 0, ack_err 0.
REQ-034 While n_rst=0, outputs SHALL be: scl_out=1, sda_out=1, busy=0, done=0, load_enable=0, shift_enable=0.
REQ-035 Reset asserted mid-transfer SHALL abort immediately with no STOP generated; the first tx_start after release starts a fresh byte.

Verification
REQ-036 HALF_PERIOD=4, data 0xA5, sda_in=0 at ACK: START, then SDA bits 1,0,1,0,0,1,0,1 each stable while SCL=1; ack_err=0; done at cycle 85.
REQ-037 Same transfer with sda_in=1 at ACK: ack_err=1 after the ACK_HIGH phase end; STOP still generated; done still at cycle 85.
REQ-038 tx_start pulsed at cycles 10, 40 and 85 during a transfer: no extra load_enable, no timing change; tx_start at cycle 86 is accepted.
REQ-039 n_rst pulsed low in BIT_HIGH of bit 3: scl_out=1, sda_out=1 and busy=0 immediately; a subsequent byte completes normally.
REQ-040 HALF_PERIOD=2: exactly 8 shift_enable pulses, each at a BIT_HIGH end; done at cycle 43.
REQ-041 Idle with tx_start=0 for 100 cycles: all outputs remain at reset values.
